fir_sample_source: RTL and testbench

Stimulus-side producer for the moving-average FIR datapath. It debounces the board push-button `toggleBtn` and, on each press, presents one 8-bit sample from a deterministic LFSR sequence on a valid/ready stream that feeds the filter input. It sits between the board I/O and the FIR core inside the FIR top level, opposite the HEX display path, which consumes filter results.

---
 rtl/fir_sample_source_if.sv | 8 +
 rtl/fir_sample_source.sv | 91 +++++++++
 tb/tb_fir_sample_source.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fir_sample_source_if.sv
// fir_sample_source_if: valid/ready sample stream from the stimulus source to the FIR input.
interface fir_sample_source_if;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic       sample_ready;
    modport master(output sample_out, sample_valid, input sample_ready);
    modport slave(input sample_out, sample_valid, output sample_ready);
endinterface

// File: rtl/fir_sample_source.sv
// fir_sample_source: debounced push-button to LFSR sample producer on a valid/ready stream.
// Optional auto-repeat while held is enabled by defining FIR_SRC_AUTO_EN.
module fir_sample_source #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_PERIOD     = 25000000
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   toggleBtn,
    output logic [7:0]             xfer_count,
    output logic                   LEDG,
    fir_sample_source_if.master    bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic          db;
    logic          db_prev;
    logic [DW-1:0] db_cnt;
    logic [0:0]    state;
    logic [7:0]    lfsr;
    logic [7:0]    lfsr_next;
    logic          rise;
    logic          press;
    logic          xfer;

    always_comb begin
        lfsr_next        = (lfsr >> 1) ^ (lfsr[0] ? 8'hB8 : 8'h00);
        rise             = db & ~db_prev;
        xfer             = (state == OFFER) & bus.sample_ready;
        bus.sample_valid = state == OFFER;
        bus.sample_out   = lfsr;
    end

`ifdef FIR_SRC_AUTO_EN
    localparam int AW = $clog2(AUTO_PERIOD + 1);
    logic [AW-1:0] auto_cnt;
    logic          auto_hit;

    // Counting starts the cycle after the initial press so repeats land AUTO_PERIOD apart.
    assign auto_hit = db & db_prev & (auto_cnt == AW'(AUTO_PERIOD - 1));
    assign press    = rise | auto_hit;

    always_ff @(posedge CLOCK_50) begin
        if (reset || !(db && db_prev))
            auto_cnt <= '0;
        else
            auto_cnt <= auto_hit ? '0 : auto_cnt + 1'b1;
    end
`else
    logic unused_auto;
    assign unused_auto = |AUTO_PERIOD;
    assign press       = rise;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync       <= '0;
            db         <= 1'b0;
            db_prev    <= 1'b0;
            db_cnt     <= '0;
            state      <= IDLE;
            lfsr       <= 8'h01;
            xfer_count <= '0;
            LEDG       <= 1'b0;
        end else begin
            sync    <= {sync[0], toggleBtn};
            db_prev <= db;
            if (sync[1] == db)
                db_cnt <= '0;
            else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                db     <= sync[1];
                db_cnt <= '0;
            end else
                db_cnt <= db_cnt + 1'b1;
            // A press coinciding with a transfer is dropped without flagging overrun.
            if (xfer) begin
                lfsr       <= lfsr_next;
                xfer_count <= xfer_count + 8'd1;
                state      <= IDLE;
            end else if (press) begin
                if (state == OFFER)
                    LEDG <= 1'b1;
                else
                    state <= OFFER;
            end
        end
    end
endmodule

// File: tb/tb_fir_sample_source.sv
// tb_fir_sample_source: scoreboard bench for fir_sample_source (DEBOUNCE_CYCLES=4, AUTO_PERIOD=8).
module tb_fir_sample_source;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic toggle_btn = 1'b0;
    logic [7:0] xfer_count;
    logic led;
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_lfsr = 8'h01;
    logic [7:0] last_sample = 8'h00;

    fir_sample_source_if bus();

    fir_sample_source #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(8)) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .toggleBtn(toggle_btn),
        .xfer_count(xfer_count),
        .LEDG(led),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic push_exp();
        exp_q.push_back(m_lfsr);
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        m_lfsr = 8'h01;
        exp_q.delete();
    endtask

    task automatic press(input bit offered);
        toggle_btn = 1'b1;
        if (offered) push_exp();
        step(6);
        toggle_btn = 1'b0;
        step(10);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.sample_valid && bus.sample_ready) begin
            last_sample = bus.sample_out;
            if (exp_q.size() == 0)
                check("unexpected_xfer", {24'd0, bus.sample_out}, 32'hFFFF_FFFF);
            else
                check("sample", {24'd0, bus.sample_out}, {24'd0, exp_q.pop_front()});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_auto;
        bus.sample_ready = 1'b1;
        do_reset();
        check("rst_valid", bus.sample_valid, 0);
        check("rst_out", bus.sample_out, 8'h01);
        check("rst_count", xfer_count, 0);
        check("rst_led", led, 0);

        toggle_btn = 1'b1;
        push_exp();
        step(6);
        check("lat_valid_early", bus.sample_valid, 0);
        step(1);
        check("lat_valid", bus.sample_valid, 1);
        check("lat_out", bus.sample_out, 8'h01);
        step(1);
        check("post_valid", bus.sample_valid, 0);
        check("post_count", xfer_count, 1);
        check("post_lfsr", bus.sample_out, 8'hB8);
        toggle_btn = 1'b0;
        step(10);
        for (int i = 0; i < 4; i++) press(1);
        check("five_count", xfer_count, 5);
        check("five_last", last_sample, 8'h17);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            toggle_btn = ~toggle_btn;
            step(2);
        end
        toggle_btn = 1'b0;
        step(12);
        check("bounce_count", xfer_count, 0);
        check("bounce_valid", bus.sample_valid, 0);

        bus.sample_ready = 1'b0;
        press(1);
        check("bp_valid", bus.sample_valid, 1);
        check("bp_led0", led, 0);
        press(0);
        check("bp_valid2", bus.sample_valid, 1);
        check("bp_out", bus.sample_out, 8'h01);
        check("bp_led1", led, 1);
        check("bp_count0", xfer_count, 0);
        bus.sample_ready = 1'b1;
        step(1);
        check("bp_xfer_valid", bus.sample_valid, 0);
        check("bp_count1", xfer_count, 1);
        step(5);
        check("bp_count_hold", xfer_count, 1);
        check("bp_led_sticky", led, 1);

        do_reset();
        check("wrap_led_clr", led, 0);
        for (int i = 0; i < 256; i++) press(1);
        check("wrap_count", xfer_count, 0);
        check("wrap_last", last_sample, 8'h01);
        check("wrap_q_empty", exp_q.size(), 0);

        do_reset();
`ifdef FIR_SRC_AUTO_EN
        n_auto = 4;
`else
        n_auto = 1;
`endif
        toggle_btn = 1'b1;
        for (int i = 0; i < n_auto; i++) push_exp();
        step(30);
        toggle_btn = 1'b0;
        step(20);
        check("auto_count", xfer_count, n_auto);
        check("auto_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
